// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mul_div_unit
// Description : Iterative radix-2 HI/LO multiply/divide unit. Executes
//               MULT/MULTU/DIV/DIVU one bit per cycle on unsigned magnitudes,
//               applies sign correction in a final FIX cycle, and holds the
//               architectural HI/LO registers (also written by MTHI/MTLO).
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk        in   rising-edge clock
//   resetN     in   asynchronous active-low reset
//   start      in   operation request, accepted only when idle
//   op         in   00 MULT, 01 MULTU, 10 DIV, 11 DIVU (sampled with start)
//   opA        in   multiplicand / dividend (sampled with start)
//   opB        in   multiplier / divisor (sampled with start)
//   abort      in   cancel the in-flight operation, HI/LO untouched
//   writeHi    in   MTHI strobe (idle only)
//   writeLo    in   MTLO strobe (idle only)
//   writeData  in   MTHI/MTLO data
//   busy       out  operation in flight
//   done       out  one-cycle pulse, HI/LO just updated by an operation
//   hi, lo     out  architectural HI/LO registers
// ============================================================================
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic             abort,
    input  logic             writeHi,
    input  logic             writeLo,
    input  logic [WIDTH-1:0] writeData,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    if (WIDTH < 4 || (WIDTH % 2) != 0) begin : g_bad_width
        $error("mul_div_unit: WIDTH must be >= 4 and even");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state, next_state;
    logic   accept;

    // Operation context captured at accept
    logic             is_div;
    logic             neg_main;   // negate product / quotient
    logic             neg_rem;    // remainder takes the dividend's sign
    logic             div_zero;
    logic [CW-1:0]    count;

    // Datapath: acc is the upper product half / partial remainder,
    // mq is the lower product half (multiplier shifts out) / quotient.
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mq;
    logic [WIDTH-1:0] b_mag;

    logic             sign_a, sign_b;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0] quo, rem;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                // abort in the same cycle as start drops the request
                if (start && !abort) begin
                    next_state = RUN;
                    accept     = 1'b1;
                end
            end
            RUN: begin
                if (abort) begin
                    next_state = IDLE;
                end else if (count == '0) begin
                    next_state = FIX;
                end
            end
            FIX:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // ------------------------------------------------------------------------
    // Operand magnitudes and per-step arithmetic
    // ------------------------------------------------------------------------
    always_comb begin
        sign_a = ~op[0] & opA[WIDTH-1];
        sign_b = ~op[0] & opB[WIDTH-1];
        // |MIN| wraps to 2^(WIDTH-1), which is correct read as unsigned
        mag_a  = sign_a ? (~opA + 1'b1) : opA;
        mag_b  = sign_b ? (~opB + 1'b1) : opB;

        // Shift-add: add multiplicand when the current multiplier bit is set
        mul_sum = {1'b0, acc} + (mq[0] ? {1'b0, b_mag} : {(WIDTH+1){1'b0}});

        // Restoring divide: partial remainder < divisor, so the trial
        // difference always fits WIDTH+1 bits with bit WIDTH as its sign.
        div_shift = {acc, mq[WIDTH-1]};
        div_diff  = div_shift - {1'b0, b_mag};

        product = {acc, mq};
        if (neg_main) begin
            product = ~product + 1'b1;
        end
        quo = neg_main ? (~mq + 1'b1) : mq;
        rem = neg_rem ? (~acc + 1'b1) : acc;
    end

    // ------------------------------------------------------------------------
    // Datapath and HI/LO registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            acc      <= '0;
            mq       <= '0;
            b_mag    <= '0;
            count    <= '0;
            is_div   <= 1'b0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc      <= '0;
                        mq       <= mag_a;
                        b_mag    <= mag_b;
                        count    <= CW'(WIDTH - 1);
                        is_div   <= op[1];
                        neg_main <= sign_a ^ sign_b;
                        neg_rem  <= sign_a;
                        div_zero <= (opB == '0);
                    end else begin
                        if (writeHi) hi <= writeData;
                        if (writeLo) lo <= writeData;
                    end
                end
                RUN: begin
                    if (is_div) begin
                        acc <= div_diff[WIDTH] ? div_shift[WIDTH-1:0]
                                               : div_diff[WIDTH-1:0];
                        mq  <= {mq[WIDTH-2:0], ~div_diff[WIDTH]};
                    end else begin
                        acc <= mul_sum[WIDTH:1];
                        mq  <= {mul_sum[0], mq[WIDTH-1:1]};
                    end
                    count <= count - 1'b1;
                end
                FIX: begin
                    if (!abort) begin
                        done <= 1'b1;
                        if (is_div) begin
                            // With a zero divisor every trial subtract succeeds,
                            // so the remainder already equals the dividend and
                            // only the quotient needs forcing to all ones.
                            lo <= div_zero ? {WIDTH{1'b1}} : quo;
                            hi <= rem;
                        end else begin
                            {hi, lo} <= product;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative, parametrised HI/LO multiply/divide unit for the MIPS core, adding MULT/MULTU/DIV/DIVU and MTHI/MTLO support that the single-cycle datapath lacks. It sits beside the ALU in EX: the core issues an operation with a one-cycle `start`, stalls on `busy`, and reads the architectural `hi`/`lo` registers held inside this block. Radix-2, one bit per cycle, operand width set by `WIDTH`.

## Interface
- `WIDTH`, 32: operand width; `hi`/`lo` are each `WIDTH` bits; must be ≥ 4 and even.
- `clk`  input  1  rising-edge clock.
- `resetN`  input  1  asynchronous, active-low reset.
- `start`  input  1  request; accepted only in IDLE.
- `op`  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with `start`.
- `opA`  input  WIDTH  multiplicand / dividend (rs); sampled with `start`.
- `opB`  input  WIDTH  multiplier / divisor (rt); sampled with `start`.
- `abort`  input  1  cancel in-flight operation (pipeline flush).
- `writeHi`, `writeLo`  input  1 each  MTHI/MTLO strobes.
- `writeData`  input  WIDTH  data for MTHI/MTLO.
- `busy`  output  1  operation in flight.
- `done`  output  1  one-cycle pulse: `hi`/`lo` just updated by an operation.
- `hi`, `lo`  output  WIDTH  architectural HI/LO registers.

## Operation
- Reset (async, `resetN`=0): state IDLE, `hi`=`lo`=0, `busy`=0, `done`=0, counter 0; takes effect immediately, including mid-operation.
- States: IDLE → RUN → FIX → IDLE.
- IDLE: `start`=1 latches `op`, operands, signs; loads counter with WIDTH−1; → RUN. Else MTHI/MTLO writes land at the edge (both may write together). `start` and a write in the same cycle: `start` wins, write dropped.
- RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle on unsigned magnitudes; counter decrements; at counter 0 → FIX.
- FIX: sign correction, writes `hi`/`lo`, pulses `done`, → IDLE.
- Signed ops: operate on |opA|, |opB| (|MIN| = 2^(WIDTH−1) as unsigned); product negated if signs differ; quotient negated if signs differ; remainder takes dividend's sign.
- Multiply: {`hi`,`lo`} = full 2·WIDTH-bit product.
- Divide: `lo` = quotient, `hi` = remainder, truncated toward zero.
- Divide by zero (signed or unsigned): `lo` = all ones, `hi` = opA; same latency, no exception.
- Signed overflow (MIN / −1): `lo` = MIN, `hi` = 0 (falls out of magnitude algorithm).
- `start`, `writeHi`, `writeLo` while `busy`: ignored, no side effects.
- `abort` in RUN or FIX: → IDLE at next edge, `hi`/`lo` keep prior values, no `done`. `abort` in IDLE: no effect; `abort`+`start` same IDLE cycle: `start` dropped.

## Timing
- `start` accepted at edge E0; `busy`=1 from after E0; RUN occupies edges E1..E(WIDTH); FIX at E(WIDTH+1): `hi`/`lo` updated, `busy`→0, `done`→1 for exactly one cycle.
- Latency WIDTH+1 cycles from accepting edge to result (33 for WIDTH=32), independent of operand values.
- New `start` accepted in the cycle `done`=1 (back-to-back throughput WIDTH+1).
- MTHI/MTLO: result visible on `hi`/`lo` the cycle after the strobe.
- All outputs registered; no combinational path input → output.

## Test plan
- Reset: `resetN`=0 mid-RUN → `busy`,`done`=0, `hi`=`lo`=0 immediately; release, block idle.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001, `done` exactly 33 cycles after accept; MULT 0xFFFFFFFD × 7 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB.
- DIV 0xFFFFFFF9 / 2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF; DIVU 0xFFFFFFF9 / 2 → `lo`=0x7FFFFFFC, `hi`=1.
- DIVU 0x1234 / 0 → `lo`=0xFFFFFFFF, `hi`=0x1234; DIV 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- Hazards: `start` and `writeHi` 0xAA during `busy` ignored (result unchanged); `abort` at cycle 10 of RUN → `busy`=0 next cycle, `hi`/`lo` unchanged, no `done`; back-to-back `start` in `done` cycle accepted.
- MTHI 0x55 then MTLO 0x66 in IDLE → `hi`=0x55, `lo`=0x66; same with WIDTH=8: MULTU 0xFF × 0xFF → `hi`=0xFE, `lo`=0x01 in 9 cycles.
